// File: rtl/hazard_control_unit.sv
// ---------------------------------------------------------------------------
// hazard_control_unit
//
// Purpose:
//   Pipeline hazard controller for a classic 5-stage core. It drives the hold
//   and flush controls of the IF/ID register, the PC write enable and the
//   ID/EX bubble insert. It detects load-use hazards and EX-stage branch/jump
//   redirects, freezes the whole pipeline while memory reports busy, and keeps
//   saturating stall/flush performance counters plus a sticky memory-wait
//   timeout flag. Control outputs are combinational (zero latency); only the
//   FSM, the flush/wait counters, the timeout flag and the performance
//   counters are registered.
//
// Ports:
//   clk              rising-edge clock
//   reset            synchronous, active-low reset
//   id_rs1/id_rs2    source registers of the instruction in ID
//   id_use_rs1/2     ID instruction actually reads rs1/rs2
//   ex_rd            destination register of the instruction in EX
//   ex_mem_read      EX instruction is a load
//   ex_branch_taken  EX resolved a taken branch or jump
//   mem_busy         instruction or data memory not ready
//   if_id_enable     IF/ID load control: 0 = load, 1 = hold
//   if_id_flush      1 = IF/ID loads zero
//   pc_write         1 = PC updates
//   id_ex_bubble     1 = ID/EX captures a NOP
//   pipe_freeze      1 = all pipeline registers hold
//   timeout_err      sticky memory-wait timeout
//   stall_cnt        saturating count of cycles with pc_write = 0
//   flush_cnt        saturating count of cycles with if_id_flush = 1
// ---------------------------------------------------------------------------
module hazard_control_unit #(
    parameter int unsigned FLUSH_CYCLES = 1,
    parameter int unsigned MAX_WAIT     = 255,
    parameter int unsigned WAIT_W       = 8,
    parameter int unsigned CNT_W        = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic [4:0]       ex_rd,
    input  logic             ex_mem_read,
    input  logic             ex_branch_taken,
    input  logic             mem_busy,
    output logic             if_id_enable,
    output logic             if_id_flush,
    output logic             pc_write,
    output logic             id_ex_bubble,
    output logic             pipe_freeze,
    output logic             timeout_err,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        FLUSH = 2'd1,
        WAIT  = 2'd2
    } state_t;

    // Flush cycles remaining after the redirect cycle itself.
    localparam logic [3:0]        FC_RELOAD   = 4'(FLUSH_CYCLES - 1);
    localparam bit                MULTI_FLUSH = (FLUSH_CYCLES > 1);
    localparam logic [WAIT_W-1:0] WAIT_LIMIT  = WAIT_W'(MAX_WAIT);

    state_t            state_q, state_d;
    logic [3:0]        fc_q, fc_d;
    logic [WAIT_W-1:0] wc_q, wc_d, wc_inc;
    logic              timeout_q, timeout_d;
    logic [CNT_W-1:0]  stall_cnt_q, flush_cnt_q;
    logic              load_use;

    // x0 is hard-wired to zero, so a load targeting it never creates a hazard.
    assign load_use = ex_mem_read && (ex_rd != 5'd0) &&
                      ((id_use_rs1 && (id_rs1 == ex_rd)) ||
                       (id_use_rs2 && (id_rs2 == ex_rd)));

    // ---------------------------------------------------------------------
    // Next-state and output logic
    // ---------------------------------------------------------------------
    always_comb begin
        if_id_enable = 1'b0;
        if_id_flush  = 1'b0;
        pc_write     = 1'b1;
        id_ex_bubble = 1'b0;
        pipe_freeze  = 1'b0;
        state_d      = state_q;
        fc_d         = fc_q;
        wc_d         = wc_q;
        timeout_d    = timeout_q;
        wc_inc       = (wc_q == '1) ? wc_q : wc_q + 1'b1;

        if (!reset) begin
            // Keep the pipeline inert while reset is held.
            if_id_enable = 1'b1;
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
            pc_write     = 1'b0;
            state_d      = RUN;
            fc_d         = 4'd0;
            wc_d         = '0;
            timeout_d    = 1'b0;
        end else if (mem_busy) begin
            // Memory stall dominates: everything holds, pending branch or
            // load-use is serviced once the memory is ready again.
            pipe_freeze  = 1'b1;
            pc_write     = 1'b0;
            if_id_enable = 1'b1;
            wc_d         = wc_inc;
            if (wc_inc == WAIT_LIMIT) begin
                timeout_d = 1'b1;
            end
            // A frozen FLUSH keeps its remaining count and resumes afterwards.
            if (state_q != FLUSH) begin
                state_d = WAIT;
            end
        end else begin
            wc_d = '0;
            if (ex_branch_taken) begin
                if_id_flush  = 1'b1;
                id_ex_bubble = 1'b1;
                fc_d         = FC_RELOAD;
                state_d      = MULTI_FLUSH ? FLUSH : RUN;
            end else if (state_q == FLUSH) begin
                // Load-use is irrelevant here: ID holds a squashed slot.
                if_id_flush  = 1'b1;
                id_ex_bubble = 1'b1;
                fc_d         = (fc_q == 4'd0) ? 4'd0 : fc_q - 4'd1;
                state_d      = (fc_d == 4'd0) ? RUN : FLUSH;
            end else if (load_use) begin
                pc_write     = 1'b0;
                if_id_enable = 1'b1;
                id_ex_bubble = 1'b1;
                state_d      = RUN;
            end else begin
                state_d = RUN;
            end
        end
    end

    // ---------------------------------------------------------------------
    // State registers
    // ---------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= RUN;
            fc_q      <= 4'd0;
            wc_q      <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            fc_q      <= fc_d;
            wc_q      <= wc_d;
            timeout_q <= timeout_d;
        end
    end

    // Saturating performance counters driven from the live control outputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (!pc_write && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + 1'b1;
            end
            if (if_id_flush && (flush_cnt_q != '1)) begin
                flush_cnt_q <= flush_cnt_q + 1'b1;
            end
        end
    end

    assign timeout_err = timeout_q;
    assign stall_cnt   = stall_cnt_q;
    assign flush_cnt   = flush_cnt_q;

endmodule

// File: tb/tb_hazard_control_unit.sv
// ---------------------------------------------------------------------------
// tb_hazard_control_unit
//
// Purpose:
//   Self-checking bench for hazard_control_unit built with FLUSH_CYCLES=2,
//   MAX_WAIT=3, CNT_W=4. A table of per-cycle records holds the inputs, the
//   expected control outputs and the expected registered counters/flag;
//   expected outputs go into a scoreboard queue when a record is driven and
//   are popped and compared when the outputs are sampled at the falling edge.
//   Hand-written sequences cover mid-operation reset and counter saturation.
// ---------------------------------------------------------------------------
module tb_hazard_control_unit;

    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic [4:0]       id_rs1, id_rs2, ex_rd;
    logic             id_use_rs1, id_use_rs2, ex_mem_read, ex_branch_taken, mem_busy;
    logic             if_id_enable, if_id_flush, pc_write, id_ex_bubble, pipe_freeze;
    logic             timeout_err;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;

    always #5 clk = ~clk;

    hazard_control_unit #(
        .FLUSH_CYCLES(2),
        .MAX_WAIT    (3),
        .WAIT_W      (8),
        .CNT_W       (CNT_W)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .id_rs1         (id_rs1),
        .id_rs2         (id_rs2),
        .id_use_rs1     (id_use_rs1),
        .id_use_rs2     (id_use_rs2),
        .ex_rd          (ex_rd),
        .ex_mem_read    (ex_mem_read),
        .ex_branch_taken(ex_branch_taken),
        .mem_busy       (mem_busy),
        .if_id_enable   (if_id_enable),
        .if_id_flush    (if_id_flush),
        .pc_write       (pc_write),
        .id_ex_bubble   (id_ex_bubble),
        .pipe_freeze    (pipe_freeze),
        .timeout_err    (timeout_err),
        .stall_cnt      (stall_cnt),
        .flush_cnt      (flush_cnt)
    );

    // Output vector order: {if_id_enable, if_id_flush, pc_write, id_ex_bubble, pipe_freeze}
    localparam logic [4:0] O_DEF = 5'b00100;
    localparam logic [4:0] O_STL = 5'b10010;
    localparam logic [4:0] O_FLS = 5'b01110;
    localparam logic [4:0] O_FRZ = 5'b10001;
    localparam logic [4:0] O_RST = 5'b11010;

    typedef struct {
        logic       rst;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       u1;
        logic       u2;
        logic [4:0] rd;
        logic       mr;
        logic       br;
        logic       busy;
        logic [4:0] exp;
        logic       chk;
        int         st;
        int         fl;
        logic       to;
    } vec_t;

    int   cmp_n = 0;
    int   err_n = 0;
    logic [4:0] sb_q[$];
    vec_t tbl[40];

    function automatic vec_t mk(input logic rst, input logic [4:0] rs1, input logic [4:0] rs2,
                                input logic u1, input logic u2, input logic [4:0] rd,
                                input logic mr, input logic br, input logic busy,
                                input logic [4:0] exp, input logic chk,
                                input int st, input int fl, input logic to);
        vec_t v;
        v.rst = rst; v.rs1 = rs1; v.rs2 = rs2; v.u1 = u1; v.u2 = u2; v.rd = rd;
        v.mr = mr; v.br = br; v.busy = busy; v.exp = exp; v.chk = chk;
        v.st = st; v.fl = fl; v.to = to;
        return v;
    endfunction

    // Short constructors for the common stimulus shapes.
    function automatic vec_t idle(input logic [4:0] exp, input logic chk,
                                  input int st, input int fl, input logic to);
        return mk(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, exp, chk, st, fl, to);
    endfunction

    function automatic vec_t lu(input logic br, input logic [4:0] exp, input logic chk,
                                input int st, input int fl, input logic to);
        return mk(1'b1, 5'd1, 5'd5, 1'b1, 1'b1, 5'd5, 1'b1, br, 1'b0, exp, chk, st, fl, to);
    endfunction

    function automatic vec_t ctl(input logic rst, input logic br, input logic busy,
                                 input logic [4:0] exp, input logic chk,
                                 input int st, input int fl, input logic to);
        return mk(rst, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, br, busy, exp, chk, st, fl, to);
    endfunction

    task automatic cmp(input string name, input int got, input int want);
        cmp_n++;
        if (got != want) begin
            err_n++;
            $display("FAIL %s: got %0d expected %0d", name, got, want);
        end
    endtask

    // One transaction per clock: drive after the rising edge, compare at the
    // falling edge.
    task automatic step(input vec_t v, input string tag);
        logic [4:0] got;
        logic [4:0] want;
        @(posedge clk);
        #1;
        reset           = v.rst;
        id_rs1          = v.rs1;
        id_rs2          = v.rs2;
        id_use_rs1      = v.u1;
        id_use_rs2      = v.u2;
        ex_rd           = v.rd;
        ex_mem_read     = v.mr;
        ex_branch_taken = v.br;
        mem_busy        = v.busy;
        sb_q.push_back(v.exp);
        @(negedge clk);
        got  = {if_id_enable, if_id_flush, pc_write, id_ex_bubble, pipe_freeze};
        want = sb_q.pop_front();
        $display("[%0t] %s rst=%b br=%b busy=%b mr=%b outs=%b exp=%b stall=%0d flush=%0d to=%b",
                 $time, tag, v.rst, v.br, v.busy, v.mr, got, want, stall_cnt, flush_cnt, timeout_err);
        cmp({tag, " outs"}, int'(got), int'(want));
        if (v.chk) begin
            cmp({tag, " stall_cnt"}, int'(stall_cnt), v.st);
            cmp({tag, " flush_cnt"}, int'(flush_cnt), v.fl);
            cmp({tag, " timeout_err"}, int'(timeout_err), int'(v.to));
        end
    endtask

    initial begin
        reset = 1'b0;
        id_rs1 = '0; id_rs2 = '0; id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
        ex_rd = '0; ex_mem_read = 1'b0; ex_branch_taken = 1'b0; mem_busy = 1'b0;

        // Reset held with random inputs.
        for (int i = 0; i < 3; i++) begin
            tbl[i] = mk(1'b0, 5'($urandom), 5'($urandom), 1'($urandom), 1'($urandom),
                        5'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                        O_RST, (i != 0), 0, 0, 1'b0);
        end
        tbl[3]  = idle(O_DEF, 1'b1, 0, 0, 1'b0);
        // Load-use through rs2, then the ex_rd = 0 and non-matching cases.
        tbl[4]  = lu(1'b0, O_STL, 1'b1, 0, 0, 1'b0);
        tbl[5]  = idle(O_DEF, 1'b1, 1, 0, 1'b0);
        tbl[6]  = mk(1'b1, 5'd0, 5'd0, 1'b0, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, O_DEF, 1'b1, 1, 0, 1'b0);
        tbl[7]  = mk(1'b1, 5'd7, 5'd3, 1'b1, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0, O_STL, 1'b1, 1, 0, 1'b0);
        tbl[8]  = mk(1'b1, 5'd7, 5'd3, 1'b0, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0, O_DEF, 1'b1, 2, 0, 1'b0);
        tbl[9]  = mk(1'b1, 5'd7, 5'd7, 1'b1, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0, O_DEF, 1'b1, 2, 0, 1'b0);
        // Single branch pulse: two flush cycles.
        tbl[10] = ctl(1'b1, 1'b1, 1'b0, O_FLS, 1'b1, 2, 0, 1'b0);
        tbl[11] = idle(O_FLS, 1'b1, 2, 1, 1'b0);
        tbl[12] = idle(O_DEF, 1'b1, 2, 2, 1'b0);
        // Branch together with load-use: flush wins, load-use ignored in FLUSH.
        tbl[13] = lu(1'b1, O_FLS, 1'b1, 2, 2, 1'b0);
        tbl[14] = lu(1'b0, O_FLS, 1'b1, 2, 3, 1'b0);
        tbl[15] = idle(O_DEF, 1'b1, 2, 4, 1'b0);
        // Memory busy for 4 cycles with a branch held, flush on the 5th.
        tbl[16] = ctl(1'b1, 1'b1, 1'b1, O_FRZ, 1'b1, 2, 4, 1'b0);
        tbl[17] = ctl(1'b1, 1'b1, 1'b1, O_FRZ, 1'b1, 3, 4, 1'b0);
        tbl[18] = ctl(1'b1, 1'b1, 1'b1, O_FRZ, 1'b1, 4, 4, 1'b0);
        tbl[19] = ctl(1'b1, 1'b1, 1'b1, O_FRZ, 1'b1, 5, 4, 1'b1);
        tbl[20] = ctl(1'b1, 1'b1, 1'b0, O_FLS, 1'b1, 6, 4, 1'b1);
        tbl[21] = idle(O_FLS, 1'b1, 6, 5, 1'b1);
        tbl[22] = idle(O_DEF, 1'b1, 6, 6, 1'b1);
        // Timeout: reset, then 5 busy cycles; flag sticky afterwards.
        tbl[23] = ctl(1'b0, 1'b0, 1'b0, O_RST, 1'b1, 6, 6, 1'b1);
        tbl[24] = ctl(1'b1, 1'b0, 1'b1, O_FRZ, 1'b1, 0, 0, 1'b0);
        tbl[25] = ctl(1'b1, 1'b0, 1'b1, O_FRZ, 1'b1, 1, 0, 1'b0);
        tbl[26] = ctl(1'b1, 1'b0, 1'b1, O_FRZ, 1'b1, 2, 0, 1'b0);
        tbl[27] = ctl(1'b1, 1'b0, 1'b1, O_FRZ, 1'b1, 3, 0, 1'b1);
        tbl[28] = ctl(1'b1, 1'b0, 1'b1, O_FRZ, 1'b1, 4, 0, 1'b1);
        tbl[29] = idle(O_DEF, 1'b1, 5, 0, 1'b1);
        tbl[30] = idle(O_DEF, 1'b1, 5, 0, 1'b1);
        // Busy in FLUSH freezes and preserves the remaining flush count.
        tbl[31] = ctl(1'b1, 1'b1, 1'b0, O_FLS, 1'b1, 5, 0, 1'b1);
        tbl[32] = ctl(1'b1, 1'b0, 1'b1, O_FRZ, 1'b1, 5, 1, 1'b1);
        tbl[33] = ctl(1'b1, 1'b0, 1'b1, O_FRZ, 1'b1, 6, 1, 1'b1);
        tbl[34] = idle(O_FLS, 1'b1, 7, 1, 1'b1);
        tbl[35] = idle(O_DEF, 1'b1, 7, 2, 1'b1);
        // Branch during FLUSH reloads the flush count.
        tbl[36] = ctl(1'b1, 1'b1, 1'b0, O_FLS, 1'b1, 7, 2, 1'b1);
        tbl[37] = ctl(1'b1, 1'b1, 1'b0, O_FLS, 1'b1, 7, 3, 1'b1);
        tbl[38] = idle(O_FLS, 1'b1, 7, 4, 1'b1);
        tbl[39] = idle(O_DEF, 1'b1, 7, 5, 1'b1);

        for (int i = 0; i < 40; i++) begin
            step(tbl[i], $sformatf("vec%0d", i));
        end

        // Reset asserted mid-FLUSH returns to RUN with fc cleared.
        step(ctl(1'b0, 1'b0, 1'b0, O_RST, 1'b0, 0, 0, 1'b0), "mf_rst0");
        step(ctl(1'b1, 1'b1, 1'b0, O_FLS, 1'b1, 0, 0, 1'b0), "mf_branch");
        step(ctl(1'b0, 1'b0, 1'b0, O_RST, 1'b1, 0, 1, 1'b0), "mf_rst");
        step(idle(O_DEF, 1'b1, 0, 0, 1'b0), "mf_after");
        cmp("mf_fc_q", int'(dut.fc_q), 0);

        // Reset asserted mid-WAIT returns to RUN.
        step(ctl(1'b1, 1'b1, 1'b1, O_FRZ, 1'b1, 0, 0, 1'b0), "mw_busy");
        step(ctl(1'b0, 1'b1, 1'b1, O_RST, 1'b1, 1, 0, 1'b0), "mw_rst");
        step(idle(O_DEF, 1'b1, 0, 0, 1'b0), "mw_after");

        // Counter saturation at 2^CNT_W-1.
        for (int i = 0; i < 20; i++) begin
            step(lu(1'b0, O_STL, 1'b0, 0, 0, 1'b0), $sformatf("sat_lu%0d", i));
        end
        step(idle(O_DEF, 1'b1, 15, 0, 1'b0), "sat_stall");
        for (int i = 0; i < 20; i++) begin
            step(ctl(1'b1, 1'b1, 1'b0, O_FLS, 1'b0, 0, 0, 1'b0), $sformatf("sat_br%0d", i));
        end
        step(idle(O_FLS, 1'b1, 15, 15, 1'b0), "sat_flush_tail");
        step(idle(O_DEF, 1'b1, 15, 15, 1'b0), "sat_flush");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, err_n);
        $finish;
    end

endmodule

// File: doc/hazard_control_unit.md
Name: hazard_control_unit

Overview:
- Drives the hold and flush controls of the IF/ID pipeline register, the PC write enable, and the ID/EX bubble insert.
- Detects load-use hazards and EX-stage branch/jump redirects.
- Freezes the pipeline while memory reports busy.
- Keeps saturating stall and flush performance counters and a sticky memory-wait timeout flag.

Parameters:
FLUSH_CYCLES, 1, cycles IF/ID is flushed per redirect (legal 1..15)
MAX_WAIT, 255, consecutive mem_busy cycles before timeout_err sets (legal 1..2^WAIT_W-1)
WAIT_W, 8, width of the internal wait counter
CNT_W, 16, width of the performance counters

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-low
id_rs1  in  5  rs1 of the instruction in ID
id_rs2  in  5  rs2 of the instruction in ID
id_use_rs1  in  1  ID instruction reads rs1
id_use_rs2  in  1  ID instruction reads rs2
ex_rd  in  5  destination register of the instruction in EX
ex_mem_read  in  1  EX instruction is a load
ex_branch_taken  in  1  EX resolved a taken branch or jump
mem_busy  in  1  instruction or data memory not ready
if_id_enable  out  1  IF/ID load control: 0 = load, 1 = hold
if_id_flush  out  1  1 = IF/ID loads zero
pc_write  out  1  1 = PC updates
id_ex_bubble  out  1  1 = ID/EX captures a NOP
pipe_freeze  out  1  1 = all pipeline registers hold
timeout_err  out  1  sticky memory-wait timeout
stall_cnt  out  CNT_W  cycles with pc_write=0
flush_cnt  out  CNT_W  cycles with if_id_flush=1

Behaviour:
- Registered state: FSM {RUN, FLUSH, WAIT}, flush counter fc (4 bits), wait counter wc (WAIT_W), timeout_err, stall_cnt, flush_cnt.
- Control outputs are combinational from the current state and inputs, so they take effect in the same cycle (zero latency).
- load_use = ex_mem_read && ex_rd!=0 && ((id_use_rs1 && id_rs1==ex_rd) || (id_use_rs2 && id_rs2==ex_rd)).
- While reset==0, outputs are forced to: if_id_enable=1, if_id_flush=1, id_ex_bubble=1, pc_write=0, pipe_freeze=0. At a clk edge with reset==0: state=RUN, fc=0, wc=0, timeout_err=0, both counters 0. Reset asserted in any state, including mid-FLUSH or mid-WAIT, returns to RUN.
- Default outputs (no event): if_id_enable=0, flush=0, bubble=0, pc_write=1, freeze=0.
- Priority in RUN and WAIT: mem_busy > ex_branch_taken > load_use.
  - mem_busy=1: freeze=1, pc_write=0, if_id_enable=1, flush=0, bubble=0. Next state WAIT. wc increments, saturating. When wc reaches MAX_WAIT, timeout_err sets; it clears only on reset. Any held branch or load-use is acted on after mem_busy drops.
  - ex_branch_taken=1: flush=1, bubble=1, pc_write=1, if_id_enable=0. If FLUSH_CYCLES>1, next state FLUSH with fc=FLUSH_CYCLES-1; otherwise stay RUN.
  - load_use=1: pc_write=0, if_id_enable=1, bubble=1, flush=0. Stays RUN; exactly one stall cycle per hazard.
- WAIT with mem_busy=0: outputs and next state follow the RUN rules for the current inputs; wc clears.
- FLUSH:
  - mem_busy=1: apply the freeze outputs; fc and state hold; wc counts as in WAIT.
  - Otherwise: flush=1, bubble=1, pc_write=1, fc decrements, and the block returns to RUN when fc reaches 0.
  - ex_branch_taken=1 in FLUSH: reload fc=FLUSH_CYCLES-1, stay FLUSH if FLUSH_CYCLES>1, otherwise return to RUN.
  - load_use is ignored in FLUSH.
- Counters: stall_cnt +1 on each cycle with pc_write=0 and reset=1; flush_cnt +1 on each cycle with if_id_flush=1 and reset=1. Both saturate at 2^CNT_W-1 and do not wrap.

Test Plan:
- Reset: hold reset=0 for 3 cycles with random inputs -> if_id_enable=1, flush=1, bubble=1, pc_write=0 throughout; after release, counters=0, timeout_err=0, default outputs.
- Load-use: ex_mem_read=1, ex_rd=5, id_rs2=5, id_use_rs2=1 for 1 cycle -> pc_write=0, if_id_enable=1, bubble=1 that cycle, stall_cnt=1. Same with ex_rd=0 -> no stall.
- Branch: FLUSH_CYCLES=2, 1-cycle ex_branch_taken pulse -> flush=1 and bubble=1 for 2 cycles, then RUN, flush_cnt=2. Branch and load_use together -> flush wins, stall_cnt unchanged.
- Memory wait: mem_busy=1 for 4 cycles with ex_branch_taken=1 held -> freeze=1, pc_write=0 for 4 cycles, no flush; flush on the 5th cycle; stall_cnt=4.
- Timeout: MAX_WAIT=3, mem_busy=1 for 5 cycles -> timeout_err rises after the 3rd busy cycle and stays 1 after mem_busy drops, until reset.
- Saturation and mid-op reset: CNT_W=4, 20 load-use cycles -> stall_cnt=15; reset asserted mid-FLUSH -> state RUN, fc=0 after the edge.
